ucsbece154a_mmio: RTL and testbench

Memory-mapped I/O block on the single-cycle MIPS core's data port, alongside data memory. Decodes the core's ALU address output, returns read data combinationally in the same cycle, and commits writes on the clock edge. Provides an LED register, a free-running cycle counter with compare-match timer flag and optional interrupt, and a byte transmit FIFO draining over a valid/ready handshake.

---
 rtl/ucsbece154a_mmio.sv | 161 ++++++++++++++++
 tb/tb_ucsbece154a_mmio.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154a_mmio.sv
// ucsbece154a_mmio: memory-mapped I/O block for the single-cycle MIPS data port.
// Region 0xFFFFxxxx, decoded on addr_i[7:2]:
//   0x00 LED (RW), 0x04 CYCLE (RO, write clears), 0x08 CMP (RW),
//   0x0C STATUS (TFLAG/FULL/EMPTY/OVF/count, W1C on TFLAG and OVF), 0x10 TXDATA (push).
// Reads are combinational. Writes commit on the rising clock edge.
// Optional feature macro: UCSBECE154A_MMIO_IRQ_EN drives irq_o from TFLAG.
// When the macro is undefined, irq_o is tied low.
// TX FIFO handshake: a byte leaves when tx_valid_o & tx_ready_i at a rising edge.
// The head byte is held stable while tx_valid_o is high and tx_ready_i is low.
module ucsbece154a_mmio #(
    parameter int LED_W    = 8,
    parameter int TX_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    output logic             hit_o,
    output logic [31:0]      rdata_o,
    output logic [LED_W-1:0] led_o,
    output logic             tx_valid_o,
    output logic [7:0]       tx_data_o,
    input  logic             tx_ready_i,
    output logic             irq_o
);

    localparam int         PTR_W   = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(TX_DEPTH);

    // Word offsets within the region (addr_i[7:2])
    localparam logic [5:0] W_LED    = 6'h00;
    localparam logic [5:0] W_CYCLE  = 6'h01;
    localparam logic [5:0] W_CMP    = 6'h02;
    localparam logic [5:0] W_STATUS = 6'h03;
    localparam logic [5:0] W_TXDATA = 6'h04;

    logic [LED_W-1:0] led_q;
    logic [31:0]      cycle_q;
    logic [31:0]      cmp_q;
    logic             tflag_q;
    logic             ovf_q;

    logic [7:0]       mem [TX_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [4:0]       count_q;

    logic [5:0] word;
    logic       wr;
    logic       wr_led, wr_cycle, wr_cmp, wr_status, wr_tx;
    logic       full, empty, pop, push_ok, push_drop, tflag_hit;
    logic       unused_addr;

    assign word  = addr_i[7:2];
    assign hit_o = (addr_i[31:16] == 16'hFFFF);
    assign wr    = we_i & hit_o;

    // addr_i[15:8] and addr_i[1:0] do not take part in decoding (aliases)
    assign unused_addr = &{1'b0, addr_i[15:8], addr_i[1:0]};

    assign wr_led    = wr && (word == W_LED);
    assign wr_cycle  = wr && (word == W_CYCLE);
    assign wr_cmp    = wr && (word == W_CMP);
    assign wr_status = wr && (word == W_STATUS);
    assign wr_tx     = wr && (word == W_TXDATA);

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == 5'd0);
    assign pop       = tx_valid_o & tx_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push_ok   = wr_tx && (!full || pop);
    assign push_drop = wr_tx && full && !pop;
    assign tflag_hit = (cycle_q == cmp_q) && (cmp_q != 32'd0);

    assign led_o      = led_q;
    assign tx_valid_o = !empty;
    assign tx_data_o  = tx_valid_o ? mem[rd_ptr_q] : 8'h00;

`ifdef UCSBECE154A_MMIO_IRQ_EN
    assign irq_o = tflag_q;
`else
    assign irq_o = 1'b0;
`endif

    // Control registers: LED, cycle counter, compare value, sticky flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q   <= '0;
            cycle_q <= 32'd0;
            cmp_q   <= 32'd0;
            tflag_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_led) begin
                led_q <= wdata_i[LED_W-1:0];
            end
            // A write clears the counter and takes priority over the increment
            cycle_q <= wr_cycle ? 32'd0 : cycle_q + 32'd1;
            if (wr_cmp) begin
                cmp_q <= wdata_i;
            end
            // Setting the flag wins over a simultaneous write-1-to-clear
            if (tflag_hit) begin
                tflag_q <= 1'b1;
            end else if (wr_status && wdata_i[0]) begin
                tflag_q <= 1'b0;
            end
            // OVF write-1-to-clear and a dropped push are mutually exclusive
            // because they target different offsets
            if (push_drop) begin
                ovf_q <= 1'b1;
            end else if (wr_status && wdata_i[3]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= 5'd0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 5'd1;
                2'b01:   count_q <= count_q - 5'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents need no reset because tx_data_o is gated by tx_valid_o
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata_i[7:0];
        end
    end

    // Combinational read mux
    always_comb begin
        rdata_o = 32'd0;
        if (hit_o) begin
            case (word)
                W_LED:    rdata_o[LED_W-1:0] = led_q;
                W_CYCLE:  rdata_o = cycle_q;
                W_CMP:    rdata_o = cmp_q;
                W_STATUS: rdata_o = {23'd0, count_q, ovf_q, empty, full, tflag_q};
                default:  rdata_o = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_ucsbece154a_mmio.sv
// Testbench for ucsbece154a_mmio.
// A driver applies one bus operation per cycle.
// A behavioural model predicts the outputs for each operation and queues the prediction.
// A negedge monitor compares the queued predictions and the transmitted byte stream against the DUT.
module tb_ucsbece154a_mmio;

    localparam int LED_W    = 8;
    localparam int TX_DEPTH = 4;
    localparam logic [31:0] LED_MASK = (LED_W == 32) ? 32'hFFFF_FFFF : 32'((64'd1 << LED_W) - 64'd1);

    localparam logic [31:0] A_LED    = 32'hFFFF_0000;
    localparam logic [31:0] A_CYCLE  = 32'hFFFF_0004;
    localparam logic [31:0] A_CMP    = 32'hFFFF_0008;
    localparam logic [31:0] A_STATUS = 32'hFFFF_000C;
    localparam logic [31:0] A_TXDATA = 32'hFFFF_0010;

    logic             clk;
    logic             reset;
    logic             we_i;
    logic [31:0]      addr_i;
    logic [31:0]      wdata_i;
    logic             hit_o;
    logic [31:0]      rdata_o;
    logic [LED_W-1:0] led_o;
    logic             tx_valid_o;
    logic [7:0]       tx_data_o;
    logic             tx_ready_i;
    logic             irq_o;

    ucsbece154a_mmio #(.LED_W(LED_W), .TX_DEPTH(TX_DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .hit_o      (hit_o),
        .rdata_o    (rdata_o),
        .led_o      (led_o),
        .tx_valid_o (tx_valid_o),
        .tx_data_o  (tx_data_o),
        .tx_ready_i (tx_ready_i),
        .irq_o      (irq_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic        hit;
        logic [31:0] rdata;
        logic [31:0] led;
        logic        valid;
        logic [7:0]  data;
        logic        irq;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] tx_exp_q[$];
    int         checks = 0;
    int         errors = 0;

    // ---------------- reference model ----------------
    logic [31:0] m_led, m_cycle, m_cmp;
    logic        m_tflag, m_ovf;
    logic [7:0]  m_fifo[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [7:0] off;
        int         n;
        off = addr[7:0] & 8'hFC;
        n   = m_fifo.size();
        if (addr[31:16] != 16'hFFFF) return 32'd0;
        case (off)
            8'h00: return m_led;
            8'h04: return m_cycle;
            8'h08: return m_cmp;
            8'h0C: return {23'd0, 5'(n), m_ovf, (n == 0), (n == TX_DEPTH), m_tflag};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_led   = 32'd0;
        m_cycle = 32'd0;
        m_cmp   = 32'd0;
        m_tflag = 1'b0;
        m_ovf   = 1'b0;
        m_fifo.delete();
        tx_exp_q.delete();
    endtask

    // Advance the model by one clock edge given the operation held during the cycle
    task automatic model_step(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic ready);
        logic       wr, match, do_pop, was_full;
        logic [7:0] off;
        off      = addr[7:0] & 8'hFC;
        wr       = we && (addr[31:16] == 16'hFFFF);
        match    = (m_cmp != 32'd0) && (m_cycle == m_cmp);
        do_pop   = (m_fifo.size() > 0) && ready;
        was_full = (m_fifo.size() == TX_DEPTH);

        m_cycle = (wr && off == 8'h04) ? 32'd0 : m_cycle + 32'd1;
        if (wr && off == 8'h00) m_led = wdata & LED_MASK;
        if (wr && off == 8'h08) m_cmp = wdata;
        if (wr && off == 8'h0C) begin
            if (wdata[0]) m_tflag = 1'b0;
            if (wdata[3]) m_ovf = 1'b0;
        end
        if (match) m_tflag = 1'b1;
        if (do_pop) void'(m_fifo.pop_front());
        if (wr && off == 8'h10) begin
            if (was_full && !do_pop) begin
                m_ovf = 1'b1;
            end else begin
                m_fifo.push_back(wdata[7:0]);
                tx_exp_q.push_back(wdata[7:0]);
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic ready);
        exp_t e;
        we_i       = we;
        addr_i     = addr;
        wdata_i    = wdata;
        tx_ready_i = ready;
        e.hit   = (addr[31:16] == 16'hFFFF);
        e.rdata = model_read(addr);
        e.led   = m_led;
        e.valid = (m_fifo.size() > 0);
        e.data  = (m_fifo.size() > 0) ? m_fifo[0] : 8'h00;
`ifdef UCSBECE154A_MMIO_IRQ_EN
        e.irq   = m_tflag;
`else
        e.irq   = 1'b0;
`endif
        exp_q.push_back(e);
        @(posedge clk);
        model_step(we, addr, wdata, ready);
        #1;
    endtask

    // Reset asserted mid-cycle; outputs must clear immediately, before any edge
    task automatic apply_reset();
        we_i       = 1'b0;
        addr_i     = A_CYCLE;
        wdata_i    = 32'd0;
        tx_ready_i = 1'b0;
        reset      = 1'b1;
        #2;
        check("reset_rdata_cycle", rdata_o, 32'd0);
        check("reset_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        check("reset_tx_data", {24'd0, tx_data_o}, 32'd0);
        check("reset_led", 32'(led_o), 32'd0);
        check("reset_irq", {31'd0, irq_o}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t       e;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("hit", {31'd0, hit_o}, {31'd0, e.hit});
                check("rdata", rdata_o, e.rdata);
                check("led", 32'(led_o), e.led);
                check("tx_valid", {31'd0, tx_valid_o}, {31'd0, e.valid});
                if (e.valid) check("tx_head", {24'd0, tx_data_o}, {24'd0, e.data});
                check("irq", {31'd0, irq_o}, {31'd0, e.irq});
            end
            if (!reset && tx_valid_o && tx_ready_i) begin
                if (tx_exp_q.size() == 0) begin
                    check("tx_stream_unexpected", {24'd0, tx_data_o}, 32'hFFFF_FFFF);
                end else begin
                    b = tx_exp_q.pop_front();
                    check("tx_stream", {24'd0, tx_data_o}, {24'd0, b});
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a, d;
        int          op;
        reset      = 1'b1;
        we_i       = 1'b0;
        addr_i     = 32'd0;
        wdata_i    = 32'd0;
        tx_ready_i = 1'b0;
        model_reset();
        apply_reset();

        // Counter counts 0, 1, 2 after reset; a non-region address does not hit
        repeat (3) drive(1'b0, A_CYCLE, 32'd0, 1'b0);
        drive(1'b0, 32'h0000_1000, 32'd0, 1'b0);
        drive(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0);

        // LED write truncates to LED_W bits
        drive(1'b1, A_LED, 32'h0000_01A5, 1'b0);
        drive(1'b0, A_LED, 32'd0, 1'b0);
        check("led_direct", 32'(led_o), 32'h0000_00A5);

        // Compare match: CMP = 10, then clear the counter
        drive(1'b1, A_CMP, 32'd10, 1'b0);
        drive(1'b1, A_CYCLE, 32'd0, 1'b0);
        repeat (14) drive(1'b0, A_STATUS, 32'd0, 1'b0);
        drive(1'b1, A_STATUS, 32'd1, 1'b0);
        repeat (3) drive(1'b0, A_STATUS, 32'd0, 1'b0);

        // Fill past full with the consumer stalled, then drain
        for (int i = 0; i < 5; i++) drive(1'b1, A_TXDATA, 32'h41 + i, 1'b0);
        repeat (2) drive(1'b0, A_STATUS, 32'd0, 1'b0);
        repeat (6) drive(1'b0, A_STATUS, 32'd0, 1'b1);

        // Clear OVF, fill, then push while full with a simultaneous pop
        drive(1'b1, A_STATUS, 32'h8, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, A_TXDATA, 32'h61 + i, 1'b0);
        drive(1'b1, A_TXDATA, 32'h55, 1'b1);
        drive(1'b0, A_STATUS, 32'd0, 1'b0);
        repeat (6) drive(1'b0, A_STATUS, 32'd0, 1'b1);

        // Counter write while running clears it
        repeat (3) drive(1'b0, A_CYCLE, 32'd0, 1'b0);
        drive(1'b1, A_CYCLE, 32'h1234_5678, 1'b0);
        drive(1'b0, A_CYCLE, 32'd0, 1'b0);

        // Reset with bytes queued and the counter running
        for (int i = 0; i < 3; i++) drive(1'b1, A_TXDATA, 32'h71 + i, 1'b0);
        apply_reset();
        repeat (3) drive(1'b0, A_CYCLE, 32'd0, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            op = $urandom_range(0, 11);
            a  = {16'hFFFF, 8'($urandom), 8'($urandom_range(0, 3))};
            d  = $urandom;
            case (op)
                0:       drive(1'b1, a | 32'h00, d, 1'($urandom));
                1:       drive(1'b1, a | 32'h08, m_cycle + $urandom_range(2, 12), 1'($urandom));
                2:       drive(1'b1, a | 32'h0C, d, 1'($urandom));
                3, 4, 5: drive(1'b1, a | 32'h10, d, ($urandom_range(0, 3) == 0));
                6:       drive(1'b1, a | 32'h04, d, 1'($urandom));
                7:       drive(1'b1, a | 32'(4 * $urandom_range(5, 63)), d, 1'($urandom));
                8:       drive(1'($urandom), {16'($urandom_range(0, 16'hFFFE)), 16'($urandom)}, d,
                               1'($urandom));
                default: drive(1'b0, a | 32'(4 * $urandom_range(0, 7)), d, 1'($urandom));
            endcase
        end

        // Drain and confirm every accepted byte was transmitted
        repeat (TX_DEPTH + 2) drive(1'b0, A_STATUS, 32'd0, 1'b1);
        @(negedge clk);
        check("tx_all_sent", 32'(tx_exp_q.size()), 32'd0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
